// File: rtl/ifft_frame_feeder.sv
// ifft_frame_feeder: ping-pong frame buffer feeding an IFFT core.
// Samples are written into bank A/B. Each completed bank is replayed as one
// unbroken burst of FRAME_LEN pushes. If the other bank is already full,
// back-to-back frames stream with no gap between them.
// Optional feature: define IFFT_FEEDER_FLUSH_EN to add a flush input. Flush
// closes a partially filled frame, and the missing tail of that frame is
// pushed as zeros.
module ifft_frame_feeder #(
  parameter int W         = 28,
  parameter int FRAME_LEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
`ifdef IFFT_FEEDER_FLUSH_EN
  input  logic         flush,
`endif
  output logic         pushin,
  output logic [W-1:0] dir,
  output logic [W-1:0] dii
);

  localparam int            AW       = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  state_t         state_next;

  logic [2*W-1:0] mem [2*FRAME_LEN];
  logic           wbank;
  logic           rbank;
  logic [AW-1:0]  wcnt;
  logic [AW-1:0]  rcnt;
  logic [1:0]     full;

  logic           accept;
  logic           frame_done;
  logic           present;
  logic           last_out;
  logic [2*W-1:0] rd_word;

  // The write side stalls only while the bank it targets still awaits readout.
  assign in_ready = !full[wbank];
  assign accept   = in_valid && in_ready;

  // A full read bank is always being presented: either the burst is starting
  // from IDLE, or the burst is continuing, since full stays set until the
  // last index of the bank has been presented.
  assign present  = full[rbank];
  assign last_out = present && (rcnt == LAST_IDX);

`ifdef IFFT_FEEDER_FLUSH_EN
  logic [AW:0] fill [2];
  logic [AW:0] fill_count;
  logic        flush_fire;

  assign flush_fire = flush && in_ready && ((wcnt != '0) || accept);
  assign fill_count = {1'b0, wcnt} + {{AW{1'b0}}, accept};
  assign frame_done = (accept && (wcnt == LAST_IDX)) || flush_fire;
  assign rd_word    = ({1'b0, rcnt} < fill[rbank]) ? mem[{rbank, rcnt}] : '0;

  // Remember how many real samples each closed bank holds so the tail reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill[0] <= '0;
      fill[1] <= '0;
    end else if (frame_done) begin
      fill[wbank] <= fill_count;
    end
  end
`else
  assign frame_done = accept && (wcnt == LAST_IDX);
  assign rd_word    = mem[{rbank, rcnt}];
`endif

  // Sample storage; contents survive reset because only the flags decide validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wbank, wcnt}] <= {in_re, in_im};
    end
  end

  // Write index and write-bank pointer advance on accepted samples and frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank <= 1'b0;
      wcnt  <= '0;
    end else if (frame_done) begin
      wbank <= ~wbank;
      wcnt  <= '0;
    end else if (accept) begin
      wcnt  <= wcnt + AW'(1);
    end
  end

  // Bank-full flags; set and clear always target different banks, so both may happen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (last_out) begin
        full[rbank] <= 1'b0;
      end
      if (frame_done) begin
        full[wbank] <= 1'b1;
      end
    end
  end

  // Read FSM next state: stay in BURST for as long as a full bank is waiting.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (present) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (present) begin
          state_next = BURST;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read state, read pointers and registered IFFT drive; outputs are zero when not pushing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rbank  <= 1'b0;
      rcnt   <= '0;
      pushin <= 1'b0;
      dir    <= '0;
      dii    <= '0;
    end else begin
      state <= state_next;
      if (present) begin
        pushin <= 1'b1;
        dir    <= rd_word[2*W-1:W];
        dii    <= rd_word[W-1:0];
        rcnt   <= rcnt + AW'(1);
        if (last_out) begin
          rbank <= ~rbank;
        end
      end else begin
        pushin <= 1'b0;
        dir    <= '0;
        dii    <= '0;
      end
    end
  end

endmodule
